// File: rtl/demo_scene_sequencer_if.sv
// Bundle between the demo top and the scene sequencer: video timing and user
// controls toward the sequencer, scene / fade / offset controls back.
interface demo_scene_sequencer_if #(
    parameter int SCENE_W = 2,
    parameter int OFS_W   = 10
);
    logic               vsync;
    logic               pause;
    logic               skip;
    logic               frame_tick;
    logic [SCENE_W-1:0] scene;
    logic [1:0]         fade;
    logic               bitmap_en;
    logic [OFS_W-1:0]   ofs_a;
    logic [OFS_W-1:0]   ofs_b;
    logic [OFS_W-1:0]   ofs_c;

    modport master (
        output vsync, pause, skip,
        input  frame_tick, scene, fade, bitmap_en, ofs_a, ofs_b, ofs_c
    );

    modport slave (
        input  vsync, pause, skip,
        output frame_tick, scene, fade, bitmap_en, ofs_a, ofs_b, ofs_c
    );
endinterface

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene controller: vsync edge detect, fade-in/show/fade-out timeline,
// three bouncing offset animators and a per-scene bitmap enable, all in the clk domain.
module demo_scene_sequencer #(
    parameter int                    NUM_SCENES     = 4,
    parameter int                    SCENE_W        = 2,
    parameter int                    SCENE_FRAMES   = 240,
    parameter int                    FADE_STEP      = 8,
    parameter int                    CNT_W          = 9,
    parameter int                    OFS_W          = 10,
    parameter int                    OFS_MAX        = 200,
    parameter logic [NUM_SCENES-1:0] SCENE_BMP_MASK = 4'b0101
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demo_scene_sequencer_if.slave bus
);
    localparam logic [1:0] ST_FADE_IN  = 2'd0;
    localparam logic [1:0] ST_SHOW     = 2'd1;
    localparam logic [1:0] ST_FADE_OUT = 2'd2;

    localparam logic [CNT_W-1:0] FADE_LAST  = CNT_W'(FADE_STEP - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCENE_FRAMES - 1);
    localparam logic [OFS_W-1:0] OFS_TOP    = OFS_W'(OFS_MAX);
    localparam logic [OFS_W-1:0] OFS_B_INIT = OFS_W'(100);
    localparam logic [OFS_W-1:0] STEP_AB    = OFS_W'(1);
    localparam logic [OFS_W-1:0] STEP_C     = OFS_W'(2);

    // Returns {next_down, next_ofs}; the extra bit keeps ofs+step from wrapping.
    function automatic logic [OFS_W:0] bounce(input logic [OFS_W-1:0] ofs,
                                              input logic             down,
                                              input logic [OFS_W-1:0] step);
        logic [OFS_W:0] ext_ofs;
        logic [OFS_W:0] ext_step;
        logic [OFS_W:0] res;
        ext_ofs  = {1'b0, ofs};
        ext_step = {1'b0, step};
        if (!down) begin
            if ((ext_ofs + ext_step) >= {1'b0, OFS_TOP}) begin
                res = {1'b1, OFS_TOP};
            end else begin
                res = {1'b0, ofs + step};
            end
        end else begin
            if (ext_ofs <= ext_step) begin
                res = {1'b0, {OFS_W{1'b0}}};
            end else begin
                res = {1'b1, ofs - step};
            end
        end
        return res;
    endfunction

    logic               vsync_q_r;
    logic               skip_q_r;
    logic               skip_pend_r;
    logic               frame_tick_r;
    logic [1:0]         state_r;
    logic [CNT_W-1:0]   frame_cnt_r;
    logic [1:0]         fade_r;
    logic [SCENE_W-1:0] scene_r;
    logic               bitmap_en_r;
    logic [OFS_W-1:0]   ofs_a_r;
    logic [OFS_W-1:0]   ofs_b_r;
    logic [OFS_W-1:0]   ofs_c_r;
    logic               down_a_r;
    logic               down_b_r;
    logic               down_c_r;

    logic               active_s;
    logic               skip_edge_s;
    logic [1:0]         state_nx_s;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [1:0]         fade_nx_s;
    logic               advance_s;
    logic [OFS_W:0]     anim_a_s;
    logic [OFS_W:0]     anim_b_s;
    logic [OFS_W:0]     anim_c_s;

    assign active_s    = frame_tick_r & ~bus.pause;
    assign skip_edge_s = bus.skip & ~skip_q_r;
    assign anim_a_s    = bounce(ofs_a_r, down_a_r, STEP_AB);
    assign anim_b_s    = bounce(ofs_b_r, down_b_r, STEP_AB);
    assign anim_c_s    = bounce(ofs_c_r, down_c_r, STEP_C);

    // Frame and skip edge detection; an active tick consumes the pending skip,
    // so an edge landing on that same clock survives for the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r    <= 1'b0;
            skip_q_r     <= 1'b0;
            frame_tick_r <= 1'b0;
            skip_pend_r  <= 1'b0;
        end else begin
            vsync_q_r    <= bus.vsync;
            skip_q_r     <= bus.skip;
            frame_tick_r <= bus.vsync & ~vsync_q_r;
            if (active_s) begin
                skip_pend_r <= skip_edge_s;
            end else begin
                skip_pend_r <= skip_pend_r | skip_edge_s;
            end
        end
    end

    // Timeline next-state: fade ramps, show hold and skip handling.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = frame_cnt_r;
        fade_nx_s  = fade_r;
        advance_s  = 1'b0;
        case (state_r)
            ST_FADE_IN: begin
                if (skip_pend_r) begin
                    cnt_nx_s = {CNT_W{1'b0}};
                    if (fade_r == 2'd0) begin
                        advance_s = 1'b1;
                    end else begin
                        state_nx_s = ST_FADE_OUT;
                    end
                end else if (frame_cnt_r == FADE_LAST) begin
                    cnt_nx_s = {CNT_W{1'b0}};
                    if (fade_r >= 2'd2) begin
                        fade_nx_s  = 2'd3;
                        state_nx_s = ST_SHOW;
                    end else begin
                        fade_nx_s = fade_r + 2'd1;
                    end
                end else begin
                    cnt_nx_s = frame_cnt_r + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (skip_pend_r || (frame_cnt_r == SHOW_LAST)) begin
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_FADE_OUT;
                end else begin
                    cnt_nx_s = frame_cnt_r + CNT_W'(1);
                end
            end
            ST_FADE_OUT: begin
                if (frame_cnt_r == FADE_LAST) begin
                    cnt_nx_s = {CNT_W{1'b0}};
                    if (fade_r <= 2'd1) begin
                        fade_nx_s  = 2'd0;
                        advance_s  = 1'b1;
                        state_nx_s = ST_FADE_IN;
                    end else begin
                        fade_nx_s = fade_r - 2'd1;
                    end
                end else begin
                    cnt_nx_s = frame_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_FADE_IN;
                cnt_nx_s   = {CNT_W{1'b0}};
                fade_nx_s  = 2'd0;
            end
        endcase
    end

    // Timeline and animator registers advance only on active ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FADE_IN;
            frame_cnt_r <= {CNT_W{1'b0}};
            fade_r      <= 2'd0;
            scene_r     <= {SCENE_W{1'b0}};
            ofs_a_r     <= {OFS_W{1'b0}};
            ofs_b_r     <= OFS_B_INIT;
            ofs_c_r     <= {OFS_W{1'b0}};
            down_a_r    <= 1'b0;
            down_b_r    <= 1'b1;
            down_c_r    <= 1'b0;
        end else if (active_s) begin
            state_r     <= state_nx_s;
            frame_cnt_r <= cnt_nx_s;
            fade_r      <= fade_nx_s;
            if (advance_s) begin
                scene_r <= scene_r + SCENE_W'(1);
            end else begin
                scene_r <= scene_r;
            end
            {down_a_r, ofs_a_r} <= anim_a_s;
            {down_b_r, ofs_b_r} <= anim_b_s;
            {down_c_r, ofs_c_r} <= anim_c_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Bitmap enable is looked up from the registered scene, one cycle behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_en_r <= SCENE_BMP_MASK[0];
        end else begin
            bitmap_en_r <= SCENE_BMP_MASK[scene_r];
        end
    end

    assign bus.frame_tick = frame_tick_r;
    assign bus.scene      = scene_r;
    assign bus.fade       = fade_r;
    assign bus.bitmap_en  = bitmap_en_r;
    assign bus.ofs_a      = ofs_a_r;
    assign bus.ofs_b      = ofs_b_r;
    assign bus.ofs_c      = ofs_c_r;
endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Self-checking bench for demo_scene_sequencer: directed scenarios plus randomized
// pause/skip traffic against a phase-position reference model.
module tb_demo_scene_sequencer;
    localparam int         FS       = 8;
    localparam int         SF       = 240;
    localparam int         TRI_P    = 400;
    localparam int         VW       = 35;
    localparam logic [3:0] BMP_MASK = 4'b0101;

    logic clk;
    logic rst_n;

    demo_scene_sequencer_if #(.SCENE_W(2), .OFS_W(10)) bus ();

    demo_scene_sequencer #(
        .NUM_SCENES(4), .SCENE_W(2), .SCENE_FRAMES(SF), .FADE_STEP(FS), .CNT_W(9),
        .OFS_W(10), .OFS_MAX(200), .SCENE_BMP_MASK(BMP_MASK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase (0 in, 1 show, 2 out), ticks spent in phase, fade the
    // fade-out started from, scene, total active ticks, pending skip.
    int   m_phase;
    int   m_n;
    int   m_f0;
    int   m_scene;
    int   m_k;
    logic m_pend;

    logic          ts;
    logic          bu;
    logic [VW-1:0] act_vec;
    logic [VW-1:0] rst_vec;
    assign act_vec = {bus.scene, bus.fade, bus.bitmap_en, bus.ofs_a, bus.ofs_b, bus.ofs_c};

    function automatic int tri_w(input int x);
        int p;
        p = x % TRI_P;
        return (p <= TRI_P / 2) ? p : TRI_P - p;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int f;
        if (m_phase == 0)      f = m_n / FS;
        else if (m_phase == 1) f = 3;
        else                   f = m_f0 - m_n / FS;
        return {2'(m_scene), 2'(f), BMP_MASK[m_scene],
                10'(tri_w(m_k)), 10'(tri_w(m_k + 300)), 10'(tri_w(2 * m_k))};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_f0 = 0; m_scene = 0; m_k = 0; m_pend = 1'b0;
    endtask

    task automatic model_tick(input logic p, input logic late);
        if (!p) begin
            m_k++;
            case (m_phase)
                0: begin
                    if (m_pend) begin
                        if (m_n / FS == 0) begin m_scene = (m_scene + 1) % 4; m_n = 0; end
                        else begin m_f0 = m_n / FS; m_phase = 2; m_n = 0; end
                    end else begin
                        m_n++;
                        if (m_n == 3 * FS) begin m_phase = 1; m_n = 0; end
                    end
                end
                1: begin
                    if (m_pend || m_n + 1 == SF) begin m_phase = 2; m_f0 = 3; m_n = 0; end
                    else m_n++;
                end
                default: begin
                    m_n++;
                    if (m_n == m_f0 * FS) begin m_scene = (m_scene + 1) % 4; m_phase = 0; m_n = 0; end
                end
            endcase
            m_pend = 1'b0;
        end
        if (late) m_pend = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.vsync = 1'b0; bus.skip = 1'b0; bus.pause = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One frame: vsync pulse, optional skip edge landing on the consuming clock.
    task automatic frame(input logic p, input logic late, output logic tick_seen, output logic bmp_upd);
        @(negedge clk); bus.vsync = 1'b1; bus.pause = p;
        @(negedge clk); bus.vsync = 1'b0; tick_seen = bus.frame_tick;
        if (late) bus.skip = 1'b1;
        @(negedge clk); bmp_upd = bus.bitmap_en; bus.skip = 1'b0;
        @(negedge clk);
        model_tick(p, late);
    endtask

    task automatic pulse_skip();
        @(negedge clk); bus.skip = 1'b1;
        @(negedge clk); bus.skip = 1'b0;
        m_pend = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (act_vec !== rst_vec) begin
            n_errors++; $display("FAIL reset_outputs: got %h expected %h", act_vec, rst_vec);
        end
        n_checks++;
        if (bus.frame_tick !== 1'b0) begin
            n_errors++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick);
        end
    endtask

    task automatic test_timeline();
        do_reset();
        for (int t = 1; t <= 288; t++) begin
            frame(1'b0, 1'b0, ts, bu);
            n_checks++;
            if (act_vec !== exp_vec() || ts !== 1'b1) begin
                n_errors++; $display("FAIL timeline t%0d: got %h tick %b expected %h tick 1", t, act_vec, ts, exp_vec());
            end
            if (t % 8 == 0 && (t <= 24 || t >= 264)) begin
                n_checks++;
                if (bus.fade !== 2'((t <= 24) ? t / 8 : (288 - t) / 8)) begin
                    n_errors++; $display("FAIL timeline_fade t%0d: got %0d", t, bus.fade);
                end
            end
            if (t == 288) begin
                n_checks++;
                if ({bus.scene, bu, bus.bitmap_en} !== {2'd1, 1'b1, 1'b0}) begin
                    n_errors++; $display("FAIL scene_wrap: got scene %0d bmp %b->%b expected 1 1->0", bus.scene, bu, bus.bitmap_en);
                end
            end
        end
    endtask

    task automatic test_animators();
        logic p;
        do_reset();
        for (int f = 0; f < 1000 && m_k < 400; f++) begin
            p = ($urandom_range(0, 3) == 0);
            frame(p, 1'b0, ts, bu);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++; $display("FAIL animators k%0d: got %h expected %h", m_k, act_vec, exp_vec());
            end
            if (!p && (m_k == 100 || m_k == 101 || m_k == 200 || m_k == 201)) begin
                n_checks++;
                if ((m_k == 100 && {bus.ofs_b, bus.ofs_c} !== {10'd0, 10'd200}) ||
                    (m_k == 101 && bus.ofs_b !== 10'd1) ||
                    (m_k == 200 && {bus.ofs_a, bus.ofs_c} !== {10'd200, 10'd0}) ||
                    (m_k == 201 && bus.ofs_a !== 10'd199)) begin
                    n_errors++; $display("FAIL bounce k%0d: got a %0d b %0d c %0d", m_k, bus.ofs_a, bus.ofs_b, bus.ofs_c);
                end
            end
        end
        n_checks++;
        if (m_k != 400) begin
            n_errors++; $display("FAIL animators_budget: got %0d ticks expected 400", m_k);
        end
    endtask

    task automatic test_pause();
        logic [VW-1:0] snap;
        int pulses;
        do_reset();
        for (int t = 0; t < 100; t++) frame(1'b0, 1'b0, ts, bu);
        snap = exp_vec();
        pulses = 0;
        for (int t = 0; t < 50; t++) begin
            frame(1'b1, 1'b0, ts, bu);
            if (ts === 1'b1) pulses++;
            n_checks++;
            if (act_vec !== snap) begin
                n_errors++; $display("FAIL pause_hold %0d: got %h expected %h", t, act_vec, snap);
            end
        end
        n_checks++;
        if (pulses != 50) begin
            n_errors++; $display("FAIL pause_ticks: got %0d expected 50", pulses);
        end
        for (int t = 101; t <= 272; t++) begin
            frame(1'b0, 1'b0, ts, bu);
            n_checks++;
            if (act_vec !== exp_vec() || (t == 264 && bus.fade !== 2'd3) || (t == 272 && bus.fade !== 2'd2)) begin
                n_errors++; $display("FAIL pause_resume t%0d: got %h expected %h", t, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_skip();
        do_reset();
        for (int t = 0; t < 3; t++) frame(1'b0, 1'b0, ts, bu);
        pulse_skip();
        frame(1'b0, 1'b0, ts, bu);
        n_checks++;
        if ({bus.scene, bus.fade} !== {2'd1, 2'd0} || act_vec !== exp_vec()) begin
            n_errors++; $display("FAIL skip_fade_in: got %h expected %h", act_vec, exp_vec());
        end
        for (int t = 0; t < 74; t++) frame(1'b0, 1'b0, ts, bu);
        pulse_skip();
        frame(1'b0, 1'b0, ts, bu);
        for (int i = 1; i <= 24; i++) begin
            if (i == 5) pulse_skip();
            frame(1'b0, 1'b0, ts, bu);
            n_checks++;
            if (act_vec !== exp_vec() || (i == 23 && bus.scene !== 2'd1) ||
                (i == 24 && {bus.scene, bus.fade} !== {2'd2, 2'd0})) begin
                n_errors++; $display("FAIL skip_show i%0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_vsync_hold();
        int pulses;
        pulses = 0;
        @(negedge clk); bus.vsync = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) pulses++;
        end
        bus.vsync = 1'b0;
        repeat (2) @(negedge clk);
        model_tick(1'b0, 1'b0);
        n_checks++;
        if (pulses != 1) begin
            n_errors++; $display("FAIL vsync_hold: got %0d ticks expected 1", pulses);
        end
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_errors++; $display("FAIL vsync_hold_state: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic p;
        logic late;
        do_reset();
        for (int f = 0; f < 600; f++) begin
            if ($urandom_range(0, 39) == 0) pulse_skip();
            p    = ($urandom_range(0, 9) < 2);
            late = ($urandom_range(0, 29) == 0);
            frame(p, late, ts, bu);
            n_checks++;
            if (act_vec !== exp_vec() || ts !== 1'b1) begin
                n_errors++; $display("FAIL random f%0d: got %h tick %b expected %h", f, act_vec, ts, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            pulse_skip();
            frame(1'b0, 1'b0, ts, bu);
        end
        for (int t = 0; t < 24; t++) frame(1'b0, 1'b0, ts, bu);
        pulse_skip();
        for (int t = 0; t < 11; t++) frame(1'b0, 1'b0, ts, bu);
        n_checks++;
        if ({bus.scene, bus.fade} !== {2'd3, 2'd2} || act_vec !== exp_vec()) begin
            n_errors++; $display("FAIL pre_reset: got %h expected %h", act_vec, exp_vec());
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act_vec !== rst_vec || bus.frame_tick !== 1'b0) begin
            n_errors++; $display("FAIL async_reset: got %h tick %b expected %h tick 0", act_vec, bus.frame_tick, rst_vec);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_vec   = {2'd0, 2'd0, 1'b1, 10'd0, 10'd100, 10'd0};
        rst_n     = 1'b0;
        bus.vsync = 1'b0;
        bus.skip  = 1'b0;
        bus.pause = 1'b0;
        model_reset();
        test_reset();
        test_timeline();
        test_animators();
        test_pause();
        test_skip();
        test_vsync_hold();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
